idli_sqi_arb_m: RTL and testbench

IDLI_SQI_ARB_M -- requirements
Module: idli_sqi_arb_m

---
 rtl/idli_pkg.sv | 24 ++
 rtl/idli_sqi_shift_m.sv | 29 ++
 rtl/idli_sqi_arb_m.sv | 142 ++++++++++++++
 tb/tb_idli_sqi_arb_m.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared types and constants for the SQI memory arbiter.
package idli_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_DATA
  } arb_state_e;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam logic [3:0] CMD_RD = 4'h3;
  localparam logic [3:0] CMD_WR = 4'h2;

  function automatic logic [3:0] cmd_nibble(input logic wr);
    return wr ? CMD_WR : CMD_RD;
  endfunction

endpackage

// File: rtl/idli_sqi_shift_m.sv
// 16-bit nibble shift register: parallel load, MS nibble out, nibble captured in at the bottom.
module idli_sqi_shift_m (
  input  logic        gck,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        shift,
  input  logic [3:0]  nib_in,
  output logic [3:0]  nib_out,
  output logic [15:0] word
);

  logic [15:0] sr_q;

  always_ff @(posedge gck or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= load_val;
    end else if (shift) begin
      sr_q <= {sr_q[11:0], nib_in};
    end
  end

  assign nib_out = sr_q[15:12];
  // Word as it stands once the current input nibble has been captured.
  assign word    = {sr_q[11:0], nib_in};

endmodule

// File: rtl/idli_sqi_arb_m.sv
// Round-robin fetch/data arbiter driving a 4-bit SQI memory in 4-cycle groups.
module idli_sqi_arb_m
  import idli_pkg::*;
(
  input  logic        i_arb_gck,
  input  logic        i_arb_rst_n,
  input  logic        i_arb_f_req,
  input  logic [15:0] i_arb_f_addr,
  output logic        o_arb_f_ack,
  input  logic        i_arb_d_req,
  input  logic        i_arb_d_wr,
  input  logic [15:0] i_arb_d_addr,
  input  logic [15:0] i_arb_d_wdata,
  output logic        o_arb_d_ack,
  output logic [15:0] o_arb_rdata,
  output logic        o_arb_sqi_sck,
  output logic        o_arb_sqi_cs_n,
  output logic        o_arb_sqi_mode,
  output logic [3:0]  o_arb_sqi_data,
  input  logic [3:0]  i_arb_sqi_data
);

  logic [1:0]  cnt_q;
  arb_state_e  state_q;
  port_e       last_q;
  port_e       port_q;
  logic        wr_q;
  logic [15:0] wdata_q;
  logic        cs_n_q;
  logic        mode_q;
  logic [3:0]  data_q;
  logic        f_ack_q;
  logic        d_ack_q;
  logic [15:0] rdata_q;

  logic        grp_end;
  logic        grant;
  logic        grant_d;
  logic        sr_load;
  logic        sr_shift;
  logic [15:0] sr_load_val;
  logic [3:0]  sr_nib;
  logic [15:0] sr_word;

  assign grp_end = (cnt_q == 2'd3);
  assign grant_d = i_arb_d_req & (~i_arb_f_req | (last_q == PORT_F));
  assign grant   = (state_q == ST_IDLE) & grp_end & (i_arb_f_req | i_arb_d_req);

  // Address is loaded at grant; write data replaces it while the last address nibble goes out.
  always_comb begin
    sr_load     = grant | ((state_q == ST_ADDR) && (cnt_q == 2'd2));
    sr_load_val = wdata_q;
    if (grant) begin
      sr_load_val = grant_d ? i_arb_d_addr : i_arb_f_addr;
    end
    sr_shift = ((state_q == ST_CMD) && grp_end) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  end

  idli_sqi_shift_m u_shift (
    .gck      (i_arb_gck),
    .rst_n    (i_arb_rst_n),
    .load     (sr_load),
    .load_val (sr_load_val),
    .shift    (sr_shift),
    .nib_in   (i_arb_sqi_data),
    .nib_out  (sr_nib),
    .word     (sr_word)
  );

  // Pin outputs are registered, so each branch sets the value for the cycle after this edge.
  always_ff @(posedge i_arb_gck or negedge i_arb_rst_n) begin
    if (!i_arb_rst_n) begin
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      last_q  <= PORT_D;
      port_q  <= PORT_F;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      cs_n_q  <= 1'b1;
      mode_q  <= 1'b1;
      data_q  <= '0;
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_q + 2'd1;
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      data_q  <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant) begin
            state_q <= ST_CMD;
            port_q  <= grant_d ? PORT_D : PORT_F;
            last_q  <= grant_d ? PORT_D : PORT_F;
            wr_q    <= grant_d & i_arb_d_wr;
            wdata_q <= i_arb_d_wdata;
          end
        end
        ST_CMD: begin
          if (cnt_q == 2'd1) cs_n_q <= 1'b0;
          if (cnt_q == 2'd2) data_q <= cmd_nibble(wr_q);
          if (grp_end) begin
            data_q  <= sr_nib;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (!grp_end || wr_q) data_q <= sr_nib;
          if (grp_end) begin
            state_q <= wr_q ? ST_DATA : ST_WAIT;
            mode_q  <= wr_q;
          end
        end
        ST_WAIT: begin
          if (grp_end) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (wr_q && !grp_end) data_q <= sr_nib;
          if (grp_end) begin
            state_q <= ST_IDLE;
            cs_n_q  <= 1'b1;
            mode_q  <= 1'b1;
            f_ack_q <= (port_q == PORT_F);
            d_ack_q <= (port_q == PORT_D);
            if (!wr_q) rdata_q <= sr_word;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_arb_f_ack    = f_ack_q;
  assign o_arb_d_ack    = d_ack_q;
  assign o_arb_rdata    = rdata_q;
  assign o_arb_sqi_cs_n = cs_n_q;
  assign o_arb_sqi_sck  = i_arb_gck & ~cs_n_q;
  assign o_arb_sqi_mode = mode_q;
  assign o_arb_sqi_data = data_q;

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Bench for idli_sqi_arb_m: transaction-offset reference model checked every cycle, plus directed scenarios.
module tb_idli_sqi_arb_m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        f_req = 1'b0;
  logic [15:0] f_addr = '0;
  logic        f_ack;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_ack;
  logic [15:0] rdata;
  logic        sck;
  logic        cs_n;
  logic        mode;
  logic [3:0]  dout;
  logic [3:0]  din = '0;
  logic [15:0] mem_word = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idli_sqi_arb_m dut (
    .i_arb_gck      (clk),
    .i_arb_rst_n    (rst_n),
    .i_arb_f_req    (f_req),
    .i_arb_f_addr   (f_addr),
    .o_arb_f_ack    (f_ack),
    .i_arb_d_req    (d_req),
    .i_arb_d_wr     (d_wr),
    .i_arb_d_addr   (d_addr),
    .i_arb_d_wdata  (d_wdata),
    .o_arb_d_ack    (d_ack),
    .o_arb_rdata    (rdata),
    .o_arb_sqi_sck  (sck),
    .o_arb_sqi_cs_n (cs_n),
    .o_arb_sqi_mode (mode),
    .o_arb_sqi_data (dout),
    .i_arb_sqi_data (din)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is described by its grant cycle g; every output is a
  // function of the offset k = cycle - g (k=0 is the first cycle after the grant edge).
  bit          armed = 1'b0;
  int          m_edges = 0;
  int          m_g = 0;
  bit          m_txn = 1'b0;
  bit          m_wr = 1'b0;
  bit          m_port = 1'b0;
  bit          m_last = 1'b1;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rdata = '0;
  logic [15:0] m_cap = '0;

  function automatic int m_len();
    return m_wr ? 12 : 16;
  endfunction

  function automatic logic m_cs_n();
    int k;
    if (!rst_n || !m_txn) return 1'b1;
    k = m_edges - m_g;
    return !(k >= 2 && k <= m_len() - 1);
  endfunction

  task automatic model_step();
    int k;
    if (!rst_n) begin
      m_txn = 1'b0; m_edges = 0; m_last = 1'b1; m_rdata = '0; m_cap = '0;
      return;
    end
    k = m_edges - m_g;
    if (m_txn && !m_wr && k >= 12 && k <= 15) begin
      m_cap = {m_cap[11:0], din};
      if (k == 15) m_rdata = m_cap;
    end
    if ((m_edges % 4 == 3) && (!m_txn || k >= m_len()) && (f_req || d_req)) begin
      m_port  = (f_req && d_req) ? !m_last : d_req;
      m_last  = m_port;
      m_txn   = 1'b1;
      m_g     = m_edges + 1;
      m_wr    = m_port ? d_wr : 1'b0;
      m_addr  = m_port ? d_addr : f_addr;
      m_wdata = d_wdata;
    end
    m_edges++;
  endtask

  logic [3:0] trace[$];
  bit         acks[$];
  int         csl = 0;
  int         hi_run = 0;
  bit         seen_low = 1'b0;

  task automatic compare_outputs();
    int k;
    logic e_mode, e_fa, e_da;
    logic [3:0] e_d;
    logic [15:0] sh;
    e_mode = 1'b1; e_d = '0; e_fa = 1'b0; e_da = 1'b0;
    if (rst_n && m_txn) begin
      k = m_edges - m_g;
      if (!m_wr && k >= 8 && k <= 15) e_mode = 1'b0;
      if (k == 3) e_d = m_wr ? 4'h2 : 4'h3;
      else if (k >= 4 && k <= 7) begin
        sh = m_addr >> (4 * (7 - k)); e_d = sh[3:0];
      end else if (m_wr && k >= 8 && k <= 11) begin
        sh = m_wdata >> (4 * (11 - k)); e_d = sh[3:0];
      end
      if (k == m_len()) begin e_fa = !m_port; e_da = m_port; end
    end
    check("cs_n", 32'(cs_n), 32'(m_cs_n()));
    check("sck_low", 32'(sck), 32'(0));
    check("mode", 32'(mode), 32'(e_mode));
    check("sqi_data", 32'(dout), 32'(e_d));
    check("f_ack", 32'(f_ack), 32'(e_fa));
    check("d_ack", 32'(d_ack), 32'(e_da));
    check("rdata", 32'(rdata), 32'(rst_n ? m_rdata : 16'h0));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      if (armed) check("sck_high", 32'(sck), 32'(!m_cs_n()));
      @(negedge clk);
      if (armed) begin
        compare_outputs();
        if (!cs_n) begin
          csl++;
          if (mode) trace.push_back(dout);
          if (hi_run > 0 && seen_low) check("cs_gap_min2", 32'(hi_run >= 2), 32'(1));
          hi_run = 0;
          seen_low = 1'b1;
        end else begin
          hi_run++;
        end
        if (f_ack) acks.push_back(1'b0);
        if (d_ack) acks.push_back(1'b1);
      end
    end
  end

  // Memory responder: returns mem_word during read DATA cycles, noise otherwise.
  initial begin
    int k;
    logic [15:0] sh;
    forever begin
      @(posedge clk); #1;
      k = m_edges - m_g;
      if (m_txn && !m_wr && k >= 12 && k <= 15) begin
        sh = mem_word >> (4 * (15 - k));
        din = sh[3:0];
      end else begin
        din = 4'($urandom);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    armed = 1'b1;
    f_req = 1'b0;
    d_req = 1'b0;
    #1;
    check("rst_cs_n_async", 32'(cs_n), 32'(1));
    repeat (3) @(negedge clk);
    check("rst_mode", 32'(mode), 32'(1));
    check("rst_data", 32'(dout), 32'(0));
    check("rst_acks", 32'({f_ack, d_ack}), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    check("rst_sck", 32'(sck), 32'(0));
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input bit port, input int bound, output int n, output int first_low);
    n = 0;
    first_low = -1;
    while (n < bound) begin
      @(posedge clk); #1;
      n++;
      if (!cs_n && first_low < 0) first_low = n;
      if (port ? d_ack : f_ack) return;
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout: no ack within %0d cycles, required one", bound);
  endtask

  task automatic check_trace(input string nm, input logic [63:0] pins, input int cnt);
    check({nm, "_len"}, 32'(trace.size()), 32'(cnt));
    for (int i = 0; i < cnt && i < trace.size(); i++)
      check(nm, 32'(trace[i]), 32'(pins[4 * (cnt - 1 - i) +: 4]));
  endtask

  initial begin
    int n;
    int fl;
    logic [63:0] pins;

    // Fetch-only read straight after reset.
    do_reset();
    mem_word = 16'hABCD;
    f_addr = 16'h1234;
    f_req = 1'b1;
    trace.delete(); csl = 0;
    wait_ack(1'b0, 40, n, fl);
    f_req = 1'b0;
    check("rd_ack_edges_from_reset", 32'(n), 32'(20));
    check("rd_cs_to_ack", 32'(n - fl), 32'(14));
    check("rd_cs_low_cycles", 32'(csl), 32'(14));
    pins = 64'h031234;
    check_trace("rd_pins", pins, 6);
    check("rd_rdata", 32'(rdata), 32'(16'hABCD));

    // Data write follows, raised mid-group.
    trace.delete(); csl = 0;
    d_addr = 16'h00FF; d_wdata = 16'hBEEF; d_wr = 1'b1; d_req = 1'b1;
    wait_ack(1'b1, 40, n, fl);
    d_req = 1'b0;
    check("wr_cs_to_ack", 32'(n - fl), 32'(10));
    check("wr_cs_low_cycles", 32'(csl), 32'(10));
    pins = 64'h0200FFBEEF;
    check_trace("wr_pins", pins, 10);
    check("wr_rdata_kept", 32'(rdata), 32'(16'hABCD));

    // Continuous simultaneous requests from reset: F, D, F, D.
    do_reset();
    acks.delete();
    f_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
    d_wr = 1'($urandom); mem_word = 16'($urandom);
    f_req = 1'b1; d_req = 1'b1;
    n = 0;
    while (acks.size() < 4 && n < 200) begin @(posedge clk); #1; n++; end
    f_req = 1'b0; d_req = 1'b0;
    check("rr_count", 32'(acks.size()), 32'(4));
    if (acks.size() >= 4) begin
      check("rr_0", 32'(acks[0]), 32'(0));
      check("rr_1", 32'(acks[1]), 32'(1));
      check("rr_2", 32'(acks[2]), 32'(0));
      check("rr_3", 32'(acks[3]), 32'(1));
    end

    // Reset during ADDR aborts the read; a fresh request then completes.
    do_reset();
    mem_word = 16'h5A5A; f_addr = 16'h4321; f_req = 1'b1;
    n = 0;
    while (cs_n && n < 40) begin @(posedge clk); #1; n++; end
    check("abort_cs_low_reached", 32'(cs_n), 32'(0));
    repeat (3) begin @(posedge clk); #1; end
    acks.delete();
    do_reset();
    repeat (24) begin @(posedge clk); #1; end
    check("abort_no_ack", 32'(acks.size()), 32'(0));
    f_req = 1'b1;
    wait_ack(1'b0, 40, n, fl);
    f_req = 1'b0;
    check("abort_fresh_latency", 32'(n - fl), 32'(14));
    check("abort_fresh_rdata", 32'(rdata), 32'(16'h5A5A));

    // Request raised at counter 1 is granted at that group's end.
    do_reset();
    @(posedge clk); #1;
    mem_word = 16'hC3E1; d_addr = 16'h0F0F; d_wr = 1'b0; d_req = 1'b1;
    wait_ack(1'b1, 40, n, fl);
    d_req = 1'b0;
    check("cnt1_ack_edges", 32'(n + 1), 32'(20));
    check("cnt1_rdata", 32'(rdata), 32'(16'hC3E1));

    // Randomised traffic with occasional drop-after-grant and one mid-run reset.
    for (int c = 0; c < 2500; c++) begin
      if (c == 1200) do_reset();
      @(posedge clk); #1;
      if (f_req && f_ack) f_req = 1'b0;
      else if (f_req && m_txn && !m_port && (m_edges - m_g) < 16 && $urandom_range(0, 9) == 0) f_req = 1'b0;
      else if (!f_req && $urandom_range(0, 3) == 0) begin
        f_req = 1'b1; f_addr = 16'($urandom);
      end
      if (d_req && d_ack) d_req = 1'b0;
      else if (d_req && m_txn && m_port && (m_edges - m_g) < 16 && $urandom_range(0, 9) == 0) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req = 1'b1; d_wr = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      if (f_ack || d_ack) mem_word = 16'($urandom);
    end
    f_req = 1'b0;
    d_req = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
